// File: rtl/dmem_pkg.sv
// Shared types and helpers for the LSU data memory: func3 codes, pipe entry layout, store byte mask.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [2:0]  func3;
    logic [1:0]  lane;
    logic        err;
    logic [31:0] word;
  } dmem_pipe_t;

  function automatic logic [3:0] byte_mask(input logic [2:0] func3, input logic [1:0] lane);
    logic [3:0] m;
    m = '0;
    case (func3)
      F3_B:    m = 4'b0001 << lane;
      F3_H:    m = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-path lane shift and sign/zero extension of the raw memory word.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    rdata   = '0;
    case (func3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata = shifted;
      F3_BU:   rdata = {24'd0, shifted[7:0]};
      F3_HU:   rdata = {16'd0, shifted[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_pipe.sv
// Byte-addressed data memory with valid/ready LSU front end and LATENCY-deep response pipe.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module dmem_lsu_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] BYTES = (ADDR_W+1)'(DEPTH_WORDS) << 2;

  logic [31:0]      mem [DEPTH_WORDS];
  dmem_pipe_t       pipe [LATENCY];
  dmem_pipe_t       last;
  dmem_pipe_t       entry;

  logic             stall;
  logic             accept;
  logic             in_range;
  logic             illegal;
  logic             req_err;
  logic [1:0]       lane_eff;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       wmask;
  logic [31:0]      wdata_sh;
  logic [31:0]      rd_word;
  logic [31:0]      aligned;

  assign last      = pipe[LATENCY-1];
  assign stall     = last.valid && !rsp_ready;
  assign req_ready = !stall;
  assign accept    = req_valid && req_ready;

  assign in_range = {1'b0, req_addr} < BYTES;
  assign word_idx = req_addr[IDX_W+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    illegal = req_we ? (req_func3 > F3_W)
                     : ((req_func3 == 3'b011) || (req_func3[2:1] == 2'b11));
    case (req_func3)
      F3_H, F3_HU: lane_eff = {req_addr[1], 1'b0};
      F3_W:        lane_eff = 2'b00;
      default:     lane_eff = req_addr[1:0];
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    case (req_func3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = (req_addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end
  assign req_err = !in_range || illegal || misaligned;
`else
  assign req_err = !in_range || illegal;
`endif

  assign wmask    = byte_mask(req_func3, lane_eff);
  assign wdata_sh = req_wdata << {lane_eff, 3'b000};

  // Store commits at the accept edge, so a load accepted on the next cycle already sees it.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_comb begin
    entry       = '0;
    entry.valid = req_valid;
    entry.we    = req_we;
    entry.func3 = req_func3;
    entry.lane  = lane_eff;
    entry.err   = req_err;
    entry.word  = (req_we || req_err) ? '0 : rd_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0] <= entry;
      for (int unsigned i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  dmem_load_align u_align (
    .func3 (last.func3),
    .lane  (last.lane),
    .word  (last.word),
    .rdata (aligned)
  );

  assign rsp_valid = last.valid;
  assign rsp_err   = last.valid && last.err;
  assign rsp_rdata = (last.valid && !last.we && !last.err) ? aligned : '0;

endmodule

// File: tb/tb_dmem_lsu_pipe.sv
// Self-checking bench for dmem_lsu_pipe against a byte-array reference model.
module tb_dmem_lsu_pipe;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  dmem_lsu_pipe #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } rec_t;

  rec_t        expq[$];
  rec_t        obsq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  ref_mem [DEPTH*4];
  logic        s_req_ready, s_rsp_valid, s_err;
  logic [31:0] s_rdata;

  // Reference: architectural load/store semantics on a flat byte array.
  function automatic void ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned     size;
    bit              sgn;
    bit              legal;
    longint unsigned a;
    logic [31:0]     v;
    legal = 1; sgn = 0; size = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; end
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 0;
    endcase
    rd = '0; err = 0; a = addr;
    if (!legal || a >= DEPTH*4) begin err = 1; return; end
    if (a % size != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      err = 1; return;
`else
      a = a - (a % size);
`endif
    end
    if (we) begin
      for (int unsigned i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int unsigned i = 0; i < size; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8*i));
      if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic tick(output bit acc);
    rec_t        r;
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    s_req_ready = req_ready; s_rsp_valid = rsp_valid; s_rdata = rsp_rdata; s_err = rsp_err;
    acc = req_valid && req_ready;
    if (rsp_valid && rsp_ready) begin
      r.rdata = rsp_rdata; r.err = rsp_err; r.cyc = cyc; obsq.push_back(r);
    end
    if (acc) begin
      ref_access(req_we, req_func3, req_addr, req_wdata, rd, er);
      r.rdata = rd; r.err = er; r.cyc = cyc; expq.push_back(r);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    bit acc;
    bit ok;
    req_valid = 1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick(acc);
      if (acc) ok = 1;
    end
    req_valid = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL issue_timeout addr=%h accepted=0 required=1", addr); end
  endtask

  task automatic drain(input string tag);
    bit acc;
    req_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 200 && obsq.size() < expq.size(); i++) tick(acc);
    repeat (LAT + 1) tick(acc);
    checks++;
    if (obsq.size() != expq.size()) begin
      errors++;
      $display("FAIL %s_rsp_count got=%0d required=%0d", tag, obsq.size(), expq.size());
    end
  endtask

  task automatic test_reset;
    rst = 1; req_valid = 0; req_we = 0; req_func3 = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b required=0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b required=0", rsp_err); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got=%h required=0", rsp_rdata); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b required=1", req_ready); end
    rst = 0;
  endtask

  task automatic test_init;
    rec_t e, o;
    rsp_ready = 1;
    for (int unsigned w = 0; w < DEPTH; w++) issue(1, 3'd2, 32'(w*4), $urandom);
    drain("init");
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL init_store got=%h/%b required=%h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_directed;
    rec_t e, o;
    rsp_ready = 1;
    issue(1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(0, 3'd2, 32'h10, 0);
    issue(0, 3'd0, 32'h13, 0);
    issue(0, 3'd4, 32'h13, 0);
    issue(0, 3'd1, 32'h12, 0);
    issue(0, 3'd5, 32'h10, 0);
    issue(1, 3'd0, 32'h11, 32'h00000055);
    issue(0, 3'd2, 32'h10, 0);
    drain("directed");
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL directed_data got=%h/%b required=%h/%b", o.rdata, o.err, e.rdata, e.err);
      end
      checks++;
      if (o.cyc - e.cyc != LAT) begin
        errors++; $display("FAIL directed_latency got=%0d required=%0d", o.cyc - e.cyc, LAT);
      end
    end
  endtask

  task automatic test_back_to_back;
    rec_t        e, o;
    logic [31:0] a;
    rsp_ready = 1;
    for (int i = 0; i < 12; i++) begin
      a = 32'($urandom_range(0, DEPTH*4 - 1));
      issue(1, 3'($urandom_range(0, 2)), a, $urandom);
      issue(0, (i % 2 == 0) ? 3'd2 : 3'd4, a, 0);
    end
    drain("b2b");
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL b2b_data got=%h/%b required=%h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_stall;
    rec_t        e, o;
    bit          acc;
    bit          ok;
    logic [31:0] rd0;
    rsp_ready = 0;
    issue(0, 3'd2, 32'h10, 0);
    issue(0, 3'd2, 32'h20, 0);
    tick(acc);
    req_valid = 1; req_we = 1; req_func3 = 3'd2; req_addr = 32'h30; req_wdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      if (i == 0) rd0 = s_rdata;
      checks++; if (s_req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready got=%b required=0", s_req_ready); end
      checks++; if (acc) begin errors++; $display("FAIL stall_accept got=1 required=0"); end
      checks++; if (s_rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_rsp_valid got=%b required=1", s_rsp_valid); end
      checks++; if (s_rdata !== rd0) begin errors++; $display("FAIL stall_rdata_stable got=%h required=%h", s_rdata, rd0); end
    end
    rsp_ready = 1; ok = 0;
    for (int i = 0; i < 16 && !ok; i++) begin tick(acc); if (acc) ok = 1; end
    req_valid = 0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_release_accept got=0 required=1"); end
    issue(0, 3'd2, 32'h30, 0);
    drain("stall");
    checks++; if (obsq.size() != 4) begin errors++; $display("FAIL stall_rsp_total got=%0d required=4", obsq.size()); end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL stall_order got=%h/%b required=%h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_errors;
    rec_t e, o;
    rsp_ready = 1;
    issue(0, 3'd2, 32'(DEPTH*4), 0);
    issue(1, 3'd2, 32'(DEPTH*4), 32'h12345678);
    issue(1, 3'd2, 32'(DEPTH*4 + 32'h10), 32'hCAFEF00D);
    issue(0, 3'd2, 32'h10, 0);
    issue(0, 3'd2, 32'(DEPTH*4 - 4), 0);
    issue(0, 3'd4, 32'(DEPTH*4 - 1), 0);
    issue(0, 3'd2, 32'hFFFFFFFC, 0);
    issue(1, 3'd2, 32'h40, 32'hA5A5A5A5);
    for (int f = 3; f < 8; f++) begin
      issue(1, 3'(f), 32'h40, 32'h5A5A5A5A);
      if (f == 3 || f >= 6) issue(0, 3'(f), 32'h40, 0);
    end
    issue(0, 3'd2, 32'h40, 0);
    issue(0, 3'd2, 32'h12, 0);
    issue(0, 3'd1, 32'h11, 0);
    issue(1, 3'd1, 32'h23, 32'h0000BEEF);
    issue(0, 3'd2, 32'h20, 0);
    drain("errors");
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL errors_rsp got=%h/%b required=%h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_random;
    rec_t e, o;
    bit   acc;
    bit   pending;
    pending = 0;
    for (int n = 0; n < 600; n++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        req_valid = 1; req_we = 1'($urandom_range(0, 1)); req_func3 = 3'($urandom_range(0, 7));
        req_wdata = $urandom;
        case ($urandom_range(0, 7))
          0:       req_addr = $urandom;
          1:       req_addr = 32'(DEPTH*4 + $urandom_range(0, 15));
          default: req_addr = 32'($urandom_range(0, DEPTH*4 - 1));
        endcase
        pending = 1;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      checks++;
      if (s_req_ready !== !(s_rsp_valid && !rsp_ready)) begin
        errors++; $display("FAIL rand_req_ready got=%b required=%b", s_req_ready, !(s_rsp_valid && !rsp_ready));
      end
      if (acc) begin pending = 0; req_valid = 0; end
    end
    rsp_ready = 1;
    for (int i = 0; i < 16 && pending; i++) begin tick(acc); if (acc) pending = 0; end
    req_valid = 0;
    drain("rand");
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL rand_rsp got=%h/%b required=%h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_midflight;
    rec_t e, o;
    bit   acc;
    rsp_ready = 0;
    issue(0, 3'd2, 32'h10, 0);
    issue(0, 3'd2, 32'h14, 0);
    issue(0, 3'd2, 32'h18, 0);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight got=%b required=1", rsp_valid); end
    rst = 1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid got=%b required=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL midrst_rsp_rdata got=%h required=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL midrst_rsp_err got=%b required=0", rsp_err); end
    @(posedge clk); #1;
    rst = 0;
    expq.delete(); obsq.delete();
    rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      tick(acc);
      checks++; if (s_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost_rsp got=%b required=0", s_rsp_valid); end
    end
    for (int unsigned w = 0; w < 16; w++) issue(0, 3'd2, 32'(w*4), 0);
    drain("midrst");
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++; $display("FAIL midrst_retained got=%h/%b required=%h/%b", o.rdata, o.err, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_back_to_back();
    test_stall();
    test_errors();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
